// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM states, command bytes and
// the default end-of-program trap encoding.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CNT,
        DATA,
        WRITE,
        RUN,
        HALTED,
        ERR
    } state_t;

    localparam logic [7:0]  CMD_IMEM          = 8'h01;
    localparam logic [7:0]  CMD_DMEM          = 8'h02;
    localparam logic [7:0]  CMD_GO            = 8'hFF;
    localparam logic [31:0] TRAP_WORD_DEFAULT = 32'h44000300;

endpackage

// File: rtl/byte_assembler.sv
// Shift-in register that builds big-endian words one byte at a time and
// flags the byte that completes a 4-byte group.
module byte_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  data_byte,
    output logic [31:0] word,
    output logic        last_byte
);

    logic [1:0] byte_count;

    // Clear wins over shift so a group boundary can discard the closing byte
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            word       <= 32'd0;
            byte_count <= 2'd0;
        end else if (shift_en) begin
            word       <= {word[23:0], data_byte};
            byte_count <= byte_count + 2'd1;
        end
    end

    assign last_byte = shift_en && (byte_count == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: writes IMEM/DMEM blocks, then releases the core
// on GO and halts it when the trap instruction is fetched.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] TRAP_WORD = TRAP_WORD_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        mem_we,
    output logic        mem_sel,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] instruction,
    output logic        cpu_run,
    output logic        done,
    output logic        error,
    output logic [31:0] run_cycles
);

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        xfer;
    logic        shift_en;
    logic        asm_clear;
    logic [31:0] asm_word;
    logic        last_byte;
    logic        cnt_second;
    logic [31:0] addr;
    logic [15:0] count;
    logic [31:0] addr_hold;
    logic [31:0] wdata_hold;

    assign xfer = in_valid && in_ready;

    byte_assembler u_asm (
        .clock     (clock),
        .reset     (reset),
        .clear     (asm_clear),
        .shift_en  (shift_en),
        .data_byte (in_data),
        .word      (asm_word),
        .last_byte (last_byte)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        asm_clear  = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                accept    = 1'b1;
                asm_clear = 1'b1;
                if (in_valid) begin
                    if (in_data == CMD_IMEM || in_data == CMD_DMEM) begin
                        state_next = ADDR;
                    end else if (in_data == CMD_GO) begin
                        state_next = RUN;
                    end else begin
                        state_next = ERR;
                    end
                end
            end
            ADDR: begin
                accept   = 1'b1;
                shift_en = in_valid;
                if (in_valid && last_byte) begin
                    state_next = (in_data[1:0] != 2'b00) ? ERR : CNT;
                end
            end
            CNT: begin
                accept   = 1'b1;
                shift_en = in_valid;
                // The count is only 2 bytes, so restart the group for DATA
                if (in_valid && cnt_second) begin
                    asm_clear  = 1'b1;
                    state_next = ({asm_word[7:0], in_data} == 16'd0) ? IDLE : DATA;
                end
            end
            DATA: begin
                accept   = 1'b1;
                shift_en = in_valid;
                if (in_valid && last_byte) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = (count == 16'd1) ? IDLE : DATA;
            end
            RUN: begin
                if (instruction == TRAP_WORD) begin
                    state_next = HALTED;
                end
            end
            HALTED: state_next = HALTED;
            ERR:    state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = accept && !reset;
    assign mem_we    = (state == WRITE) && !reset;
    assign cpu_run   = (state == RUN);
    assign done      = (state == HALTED);
    assign error     = (state == ERR);
    assign mem_addr  = (state == WRITE) ? addr : addr_hold;
    assign mem_wdata = (state == WRITE) ? asm_word : wdata_hold;

    // Address/count bookkeeping; the write port holds its last value between strobes
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_sel    <= 1'b0;
            cnt_second <= 1'b0;
            addr       <= 32'd0;
            count      <= 16'd0;
            addr_hold  <= 32'd0;
            wdata_hold <= 32'd0;
            run_cycles <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_second <= 1'b0;
                    if (xfer && (in_data == CMD_IMEM || in_data == CMD_DMEM)) begin
                        mem_sel <= (in_data == CMD_DMEM);
                    end
                end
                ADDR: begin
                    if (xfer && last_byte) begin
                        addr <= {asm_word[23:0], in_data};
                    end
                end
                CNT: begin
                    if (xfer) begin
                        cnt_second <= !cnt_second;
                        if (cnt_second) begin
                            count <= {asm_word[7:0], in_data};
                        end
                    end
                end
                WRITE: begin
                    addr_hold  <= addr;
                    wdata_hold <= asm_word;
                    addr       <= addr + 32'd4;
                    count      <= count - 16'd1;
                end
                RUN: begin
                    run_cycles <= run_cycles + 32'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: block loads, address wrap, run/trap,
// protocol errors, handshake gaps and reset in the middle of a load.
module tb_program_loader;
    import loader_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        mem_we;
    logic        mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] instruction = 32'h0;
    logic        cpu_run;
    logic        done;
    logic        error;
    logic [31:0] run_cycles;

    int total = 0;
    int bad = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic        wr_sel[$];
    int          wr_cycle[$];
    int          cyc = 0;
    int          ready_in_write = 0;
    int          run_count = 0;
    int          gaps[8] = '{0, 2, 1, 3, 0, 1, 2, 0};
    logic [7:0]  s[$];

    always #5 clock = ~clock;

    program_loader dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .mem_we      (mem_we),
        .mem_sel     (mem_sel),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .instruction (instruction),
        .cpu_run     (cpu_run),
        .done        (done),
        .error       (error),
        .run_cycles  (run_cycles)
    );

    // Record every write strobe and run cycle, sampled mid-cycle
    always @(negedge clock) begin
        cyc++;
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_sel.push_back(mem_sel);
            wr_cycle.push_back(cyc);
            if (in_ready) ready_in_write++;
        end
        if (cpu_run) run_count++;
    end

    task do_reset;
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(negedge clock);
        wr_addr.delete();
        wr_data.delete();
        wr_sel.delete();
        wr_cycle.delete();
        ready_in_write = 0;
        run_count = 0;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data = b;
        while (!in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) begin
            total++;
            bad++;
            $display("[TB] FAIL handshake_timeout byte=%h ready=%b want=1", b, in_ready);
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task send_seq(input int with_gaps);
        for (int i = 0; i < s.size(); i++) begin
            if (with_gaps != 0) repeat (gaps[i % 8]) @(negedge clock);
            send_byte(s[i]);
        end
    endtask

    task test_reset;
        do_reset();
        total++; if (in_ready !== 1'b1)   begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (mem_we !== 1'b0)     begin bad++; $display("[TB] FAIL reset_mem_we got=%b want=0", mem_we); end
        total++; if ({cpu_run, done, error} !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags got=%b want=000", {cpu_run, done, error}); end
        total++; if (run_cycles !== 32'd0) begin bad++; $display("[TB] FAIL reset_run_cycles got=%h want=0", run_cycles); end
        total++; if ({mem_addr, mem_wdata, mem_sel} !== 65'd0) begin bad++; $display("[TB] FAIL reset_mem_port got=%h/%h/%b want=0", mem_addr, mem_wdata, mem_sel); end
    endtask

    task test_imem_load;
        do_reset();
        s = {8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h02,
             8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
        send_seq(0);
        repeat (3) @(negedge clock);
        total++;
        if (wr_addr.size() !== 2) begin
            bad++; $display("[TB] FAIL imem_write_count got=%0d want=2", wr_addr.size());
        end else begin
            total++; if ({wr_addr[0], wr_data[0], wr_sel[0]} !== {32'h10, 32'hDEADBEEF, 1'b0}) begin bad++; $display("[TB] FAIL imem_w0 got=%h/%h/%b want=00000010/deadbeef/0", wr_addr[0], wr_data[0], wr_sel[0]); end
            total++; if ({wr_addr[1], wr_data[1], wr_sel[1]} !== {32'h14, 32'h01234567, 1'b0}) begin bad++; $display("[TB] FAIL imem_w1 got=%h/%h/%b want=00000014/01234567/0", wr_addr[1], wr_data[1], wr_sel[1]); end
            total++; if (wr_cycle[1] - wr_cycle[0] !== 5) begin bad++; $display("[TB] FAIL imem_spacing got=%0d want=5", wr_cycle[1] - wr_cycle[0]); end
        end
        total++; if (ready_in_write !== 0) begin bad++; $display("[TB] FAIL imem_ready_in_write got=%0d want=0", ready_in_write); end
        total++; if ({in_ready, error} !== 2'b10) begin bad++; $display("[TB] FAIL imem_idle got=%b want=10", {in_ready, error}); end
        total++; if ({mem_addr, mem_wdata} !== {32'h14, 32'h01234567}) begin bad++; $display("[TB] FAIL imem_hold got=%h/%h want=00000014/01234567", mem_addr, mem_wdata); end
    endtask

    task test_dmem_wrap;
        do_reset();
        s = {8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'h00, 8'h02,
             8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
        send_seq(0);
        repeat (3) @(negedge clock);
        total++;
        if (wr_addr.size() !== 2) begin
            bad++; $display("[TB] FAIL dmem_write_count got=%0d want=2", wr_addr.size());
        end else begin
            total++; if ({wr_addr[0], wr_data[0], wr_sel[0]} !== {32'hFFFFFFFC, 32'h11111111, 1'b1}) begin bad++; $display("[TB] FAIL dmem_w0 got=%h/%h/%b want=fffffffc/11111111/1", wr_addr[0], wr_data[0], wr_sel[0]); end
            total++; if ({wr_addr[1], wr_data[1], wr_sel[1]} !== {32'h0, 32'h22222222, 1'b1}) begin bad++; $display("[TB] FAIL dmem_w1_wrap got=%h/%h/%b want=00000000/22222222/1", wr_addr[1], wr_data[1], wr_sel[1]); end
        end
    endtask

    task test_run_trap;
        do_reset();
        instruction = TRAP_WORD_DEFAULT;
        s = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h44, 8'h00, 8'h03, 8'h00};
        send_seq(0);
        @(negedge clock);
        total++; if ({cpu_run, done} !== 2'b00) begin bad++; $display("[TB] FAIL trap_during_load got=%b want=00", {cpu_run, done}); end
        total++;
        if (wr_addr.size() !== 1 || wr_data[0] !== 32'h44000300) begin
            bad++; $display("[TB] FAIL trap_load_write got=%0d writes want=1 of 44000300", wr_addr.size());
        end
        send_byte(CMD_GO);
        instruction = 32'h0;
        repeat (9) @(negedge clock);
        instruction = TRAP_WORD_DEFAULT;
        repeat (4) @(negedge clock);
        total++; if (run_count !== 10) begin bad++; $display("[TB] FAIL run_high_cycles got=%0d want=10", run_count); end
        total++; if (run_cycles !== 32'd10) begin bad++; $display("[TB] FAIL run_cycles got=%0d want=10", run_cycles); end
        total++; if ({done, cpu_run, in_ready} !== 3'b100) begin bad++; $display("[TB] FAIL halted_flags got=%b want=100", {done, cpu_run, in_ready}); end
        instruction = 32'h0;
    endtask

    task test_trap_first_cycle;
        do_reset();
        instruction = TRAP_WORD_DEFAULT;
        send_byte(CMD_GO);
        repeat (3) @(negedge clock);
        total++; if (run_cycles !== 32'd1) begin bad++; $display("[TB] FAIL first_cycle_trap got=%0d want=1", run_cycles); end
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL first_cycle_done got=%b want=1", done); end
        instruction = 32'h0;
    endtask

    task test_error_cmd;
        do_reset();
        send_byte(8'h07);
        @(negedge clock);
        total++; if ({error, in_ready} !== 2'b10) begin bad++; $display("[TB] FAIL err_cmd_flags got=%b want=10", {error, in_ready}); end
        s = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        in_valid = 1'b1;
        for (int i = 0; i < s.size(); i++) begin
            in_data = s[i];
            @(negedge clock);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        total++; if (wr_addr.size() !== 0) begin bad++; $display("[TB] FAIL err_cmd_writes got=%0d want=0", wr_addr.size()); end
        total++; if ({error, done, cpu_run} !== 3'b100) begin bad++; $display("[TB] FAIL err_cmd_sticky got=%b want=100", {error, done, cpu_run}); end
    endtask

    task test_error_addr;
        do_reset();
        s = {8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
        send_seq(0);
        in_valid = 1'b1;
        in_data = 8'h00;
        repeat (10) @(negedge clock);
        in_valid = 1'b0;
        total++; if ({error, in_ready} !== 2'b10) begin bad++; $display("[TB] FAIL err_addr_flags got=%b want=10", {error, in_ready}); end
        total++; if (wr_addr.size() !== 0) begin bad++; $display("[TB] FAIL err_addr_writes got=%0d want=0", wr_addr.size()); end
    endtask

    task test_gaps;
        do_reset();
        s = {8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03,
             8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h0B, 8'hAD, 8'hF0, 8'h0D,
             8'h12, 8'h34, 8'h56, 8'h78};
        send_seq(1);
        repeat (3) @(negedge clock);
        total++;
        if (wr_addr.size() !== 3) begin
            bad++; $display("[TB] FAIL gaps_write_count got=%0d want=3", wr_addr.size());
        end else begin
            total++; if ({wr_addr[0], wr_data[0]} !== {32'h100, 32'hCAFEBABE}) begin bad++; $display("[TB] FAIL gaps_w0 got=%h/%h want=00000100/cafebabe", wr_addr[0], wr_data[0]); end
            total++; if ({wr_addr[1], wr_data[1]} !== {32'h104, 32'h0BADF00D}) begin bad++; $display("[TB] FAIL gaps_w1 got=%h/%h want=00000104/0badf00d", wr_addr[1], wr_data[1]); end
            total++; if ({wr_addr[2], wr_data[2]} !== {32'h108, 32'h12345678}) begin bad++; $display("[TB] FAIL gaps_w2 got=%h/%h want=00000108/12345678", wr_addr[2], wr_data[2]); end
        end
        total++; if (ready_in_write !== 0) begin bad++; $display("[TB] FAIL gaps_ready_in_write got=%0d want=0", ready_in_write); end
    endtask

    task test_zero_count;
        do_reset();
        s = {8'h01, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00};
        send_seq(0);
        repeat (3) @(negedge clock);
        total++; if (wr_addr.size() !== 0) begin bad++; $display("[TB] FAIL zero_count_writes got=%0d want=0", wr_addr.size()); end
        total++; if ({in_ready, error} !== 2'b10) begin bad++; $display("[TB] FAIL zero_count_idle got=%b want=10", {in_ready, error}); end
    endtask

    task test_reset_midload;
        do_reset();
        s = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB};
        send_seq(0);
        do_reset();
        s = {8'h01, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_seq(0);
        repeat (3) @(negedge clock);
        total++;
        if (wr_addr.size() !== 1) begin
            bad++; $display("[TB] FAIL midload_write_count got=%0d want=1", wr_addr.size());
        end else begin
            total++; if ({wr_addr[0], wr_data[0]} !== {32'h20, 32'hAABBCCDD}) begin bad++; $display("[TB] FAIL midload_w0 got=%h/%h want=00000020/aabbccdd", wr_addr[0], wr_data[0]); end
        end
        total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL midload_error got=%b want=0", error); end
    endtask

    initial begin
        test_reset();
        test_imem_load();
        test_dmem_wrap();
        test_run_trap();
        test_trap_first_cycle();
        test_error_cmd();
        test_error_addr();
        test_gaps();
        test_zero_count();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
